// File: rtl/gpgpu_mon_pkg.sv
// Shared types for the OBI kernel monitor.
// mon_state_e : monitor FSM states (encoding is visible on state_o)
// mon_err_e   : sticky error causes (encoding is visible on err_code_o)
// DONE_WORD_VALUE : value whose full-word write to the done address ends a kernel
package gpgpu_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_e;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    UNDERFLOW = 2'd1,
    OVERFLOW  = 2'd2,
    LATE_REQ  = 2'd3
  } mon_err_e;

  localparam logic [31:0] DONE_WORD_VALUE = 32'h1;

endpackage

// File: rtl/obi_outstanding_tracker.sv
// Outstanding-response tracker for one OBI channel.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        synchronous clear, zeroes the counter and masks the flags
//   acc_i          request accepted this cycle (req & gnt)
//   rvalid_i       response returned this cycle
//   underflow_o    rvalid with nothing outstanding and no same-cycle accept
//   overflow_o     accept that would exceed MAX_OUTSTANDING
module obi_outstanding_tracker #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic acc_i,
  input  logic rvalid_i,
  output logic underflow_o,
  output logic overflow_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt_q, cnt_d;

  // An accept and a response in the same cycle cancel out, so only the
  // unbalanced cases move the counter or raise a flag. Out-of-range moves
  // are flagged and the counter is held at its bound.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    overflow_o  = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (acc_i && !rvalid_i) begin
      if (cnt_q == MAX_CNT) overflow_o = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (rvalid_i && !acc_i) begin
      if (cnt_q == '0) underflow_o = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/obi_kernel_monitor.sv
// Passive monitor on the instruction and data OBI channels of the GPGPU.
// Detects kernel start (first accepted fetch) and completion (accepted
// full-word write of DONE_WORD_VALUE to DONE_ADDR), counts RUNNING cycles
// and data reads/writes, and flags protocol errors and timeout.
// Ports:
//   clk_i, rst_i, clear_i               clock, async reset, sync clear
//   instr_req_i/gnt_i/rvalid_i          instruction channel snoop
//   data_req_i/gnt_i/we_i/be_i/addr_i/wdata_i/rvalid_i  data channel snoop
//   state_o, done_o, timeout_o          FSM state and terminal levels
//   cycles_o, rd_cnt_o, wr_cnt_o        saturating counters
//   err_o, err_code_o                   sticky first protocol error
module obi_kernel_monitor
  import gpgpu_mon_pkg::*;
#(
  parameter logic [31:0] DONE_ADDR       = 32'h0000_7C00,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1_000_000,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             instr_req_i,
  input  logic             instr_gnt_i,
  input  logic             instr_rvalid_i,
  input  logic             data_req_i,
  input  logic             data_gnt_i,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  input  logic             data_rvalid_i,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic             err_o,
  output logic [1:0]       err_code_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             err_q, err_d;
  mon_err_e         err_code_q, err_code_d;

  logic instr_acc, data_acc, done_wr;
  logic instr_uf, instr_ov, data_uf, data_ov;
  logic unused_addr_lsb;

  assign instr_acc = instr_req_i & instr_gnt_i;
  assign data_acc  = data_req_i & data_gnt_i;

  // The done word is decoded on word address only; byte offset is ignored.
  assign done_wr = data_acc & data_we_i & (data_be_i == 4'hF) &
                   (data_addr_i[31:2] == DONE_ADDR[31:2]) &
                   (data_wdata_i == DONE_WORD_VALUE);
  assign unused_addr_lsb = ^data_addr_i[1:0];

  obi_outstanding_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_instr_trk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .acc_i       (instr_acc),
    .rvalid_i    (instr_rvalid_i),
    .underflow_o (instr_uf),
    .overflow_o  (instr_ov)
  );

  obi_outstanding_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_data_trk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .acc_i       (data_acc),
    .rvalid_i    (data_rvalid_i),
    .underflow_o (data_uf),
    .overflow_o  (data_ov)
  );

  always_comb begin
    state_d    = state_q;
    cycles_d   = cycles_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    if (clear_i) begin
      state_d    = IDLE;
      cycles_d   = '0;
      rd_cnt_d   = '0;
      wr_cnt_d   = '0;
      err_d      = 1'b0;
      err_code_d = NONE;
    end else begin
      case (state_q)
        IDLE: if (instr_acc) state_d = RUNNING;
        RUNNING: begin
          cycles_d = sat_inc(cycles_q);
          if (data_acc) begin
            if (data_we_i) wr_cnt_d = sat_inc(wr_cnt_q);
            else           rd_cnt_d = sat_inc(rd_cnt_q);
          end
          // Done write beats a timeout landing on the same cycle.
          if (done_wr)
            state_d = DONE;
          else if ((TIMEOUT_CYCLES != 32'd0) && (cycles_d == TIMEOUT_LIM))
            state_d = TIMEOUT;
        end
        default: ;
      endcase
      // Only the first error is recorded; same-cycle causes are ranked
      // underflow, overflow, late request.
      if (!err_q) begin
        if (instr_uf || data_uf) begin
          err_d      = 1'b1;
          err_code_d = UNDERFLOW;
        end else if (instr_ov || data_ov) begin
          err_d      = 1'b1;
          err_code_d = OVERFLOW;
        end else if (data_acc && (state_q == DONE)) begin
          err_d      = 1'b1;
          err_code_d = LATE_REQ;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cycles_q   <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= NONE;
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign state_o    = state_q;
  assign done_o     = (state_q == DONE);
  assign timeout_o  = (state_q == TIMEOUT);
  assign cycles_o   = cycles_q;
  assign rd_cnt_o   = rd_cnt_q;
  assign wr_cnt_o   = wr_cnt_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

endmodule

// File: doc/obi_kernel_monitor.md
Name: obi_kernel_monitor

Overview:
- Passive snooper on the instruction and data OBI channels between gpgpu_top and dual_port_ram.
- Detects kernel start (first accepted instruction fetch) and kernel completion (accepted full-word write of 1 to the done address).
- Counts cycles and data-port transactions, tracks outstanding responses, and flags protocol errors and timeout.
- Replaces bench-side memory polling; drives no OBI signal.

Parameters:
- DONE_ADDR, 32'h0000_7C00, byte address of the done word (word 7936).
- TIMEOUT_CYCLES, 32'd1_000_000, RUNNING cycles before timeout; 0 disables timeout.
- MAX_OUTSTANDING, 4, maximum in-flight requests per channel before an error is flagged.
- CNT_W, 32, width of all counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous clear: return to IDLE and zero all counters
- instr_req_i  in  1  instruction OBI req
- instr_gnt_i  in  1  instruction OBI gnt
- instr_rvalid_i  in  1  instruction OBI rvalid
- data_req_i  in  1  data OBI req
- data_gnt_i  in  1  data OBI gnt
- data_we_i  in  1  data OBI write enable
- data_be_i  in  4  data OBI byte enables
- data_addr_i  in  32  data OBI address (byte)
- data_wdata_i  in  32  data OBI write data
- data_rvalid_i  in  1  data OBI rvalid
- state_o  out  2  FSM state (0 IDLE, 1 RUNNING, 2 DONE, 3 TIMEOUT)
- done_o  out  1  level, high in DONE
- timeout_o  out  1  level, high in TIMEOUT
- cycles_o  out  CNT_W  RUNNING cycle count
- rd_cnt_o  out  CNT_W  accepted data reads
- wr_cnt_o  out  CNT_W  accepted data writes
- err_o  out  1  sticky protocol error
- err_code_o  out  2  first error cause (1 underflow, 2 overflow, 3 request after DONE)

Behaviour:
- Reset (rst_i high, asynchronous): state IDLE, all outputs 0.
- Accept events: instr_acc = instr_req_i & instr_gnt_i; data_acc = data_req_i & data_gnt_i.
- FSM transitions:
  - IDLE -> RUNNING on the cycle after instr_acc.
  - RUNNING -> DONE on the cycle after a done write: data_acc & data_we_i & data_be_i==4'hF & data_addr_i[31:2]==DONE_ADDR[31:2] & data_wdata_i==32'h1.
  - A write of any other value or byte enable to DONE_ADDR is counted but does not complete the kernel.
  - RUNNING -> TIMEOUT when cycles_o reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0). Done write and timeout in the same cycle: DONE wins.
  - DONE and TIMEOUT are terminal until clear_i or rst_i.
- cycles_o increments every RUNNING cycle, including the cycle of the done write; saturates at all-ones, no wrap.
- rd_cnt_o / wr_cnt_o increment on data_acc in RUNNING only, by data_we_i. Saturating.
- Outstanding counters, one per channel, width clog2(MAX_OUTSTANDING+1):
  - +1 on accept, -1 on rvalid; simultaneous accept and rvalid leaves the counter unchanged.
  - rvalid with counter 0 and no same-cycle accept: err code 1; counter held at 0.
  - Accept that would exceed MAX_OUTSTANDING: err code 2; counter saturates.
  - data_acc while in DONE: err code 3.
- err_o and err_code_o: set on the first error, hold until clear_i/rst_i. Later errors do not overwrite err_code_o.
- All outputs are registered; every event is visible 1 cycle after the accept edge.
- clear_i has priority over all events in the same cycle. The counters' next value is 0, not 0+1.
- Reset mid-operation: immediate return to IDLE and zero, regardless of in-flight transactions. Rvalids arriving afterward with outstanding = 0 flag err code 1. The bench applies reset only when the channels are idle.

Decomposition:
- gpgpu_mon_pkg holds:
  - mon_state_e (IDLE, RUNNING, DONE, TIMEOUT)
  - mon_err_e (NONE, UNDERFLOW, OVERFLOW, LATE_REQ)
  - DONE_WORD_VALUE = 32'h1
- One sub-module, obi_outstanding_tracker (counter plus underflow/overflow flags), instantiated twice: instruction and data channel.

Test Plan:
- Reset then idle 50 cycles: state_o=0, all counters 0, err_o=0. One instr accept at cycle 10: state_o=1 at cycle 11; cycles_o=5 five cycles later.
- RUNNING, 3 data reads and 2 writes, then done write (addr 0x7C00, be 4'hF, wdata 1) at RUNNING cycle 20: done_o=1 the next cycle; rd_cnt_o=3, wr_cnt_o=3, cycles_o=20 and frozen.
- Write wdata 2 to 0x7C00, then be 4'h1 with wdata 1: state stays RUNNING, wr_cnt_o=2. The following full write of 1 sets DONE.
- TIMEOUT_CYCLES=100, no done write: timeout_o=1 after 100 RUNNING cycles, cycles_o=100. Done write on that same cycle instead: done_o=1, timeout_o=0.
- Data rvalid with nothing outstanding: err_o=1, err_code_o=1. Then 5 accepts without rvalid: err_code_o stays 1.
- Assert clear_i in DONE with a simultaneous data accept: next cycle state_o=0, all counters 0, err_o=0 (no late-request error).
